alux64: RTL and testbench
=========================

ALUX64 -- requirements
Module: alux64

Interface
REQ-001 The module SHALL have one clock, `clk` (input, 1 bit), with all state updating on its rising edge.
REQ-002 The module SHALL have `rst` (input, 1 bit); reset is synchronous and active-high.
REQ-003 `A` SHALL be an input, 64 bits: operand A.
REQ-004 `B` SHALL be an input, 64 bits: operand B.
REQ-005 `Cin` SHALL be an input, 1 bit: carry-in, used by ops 0, 1, 3, 5 and 7.
REQ-006 `S` SHALL be an input, 4 bits: operation select.
REQ-007 `O` SHALL be an output, 64 bits: registered result.
REQ-008 `Cout` SHALL be an output, 1 bit: registered carry / shifted-out bit.
REQ-009 `Oflow` SHALL be an output, 1 bit: registered signed overflow.
REQ-010 `Ntive` SHALL be an output, 1 bit: registered negative flag.
REQ-011 `Zero` SHALL be an output, 1 bit: registered zero flag.

Function
REQ-012 On each rising `clk` edge with `rst`=0, all outputs SHALL load the result of the current `A`, `B`, `Cin` and `S`; latency is exactly 1 cycle, with no handshake and a new operation every cycle.
REQ-013 Arithmetic ops SHALL use one 65-bit adder; `Cout` is adder bit 64, i.e. for subtraction `Cout`=1 means no borrow.
- 0x0: A+Cin
- 0x1: B+Cin
- 0x2: A+B
- 0x3: A+B+Cin
- 0x4: A+~B+1 (A−B)
- 0x5: A+~B+Cin
- 0x6: B+~A+1 (B−A)
- 0x7: B+~A+Cin
REQ-014 For ops 0x0–0x7, `Oflow` SHALL be 1 when both adder operand MSBs are equal and the result MSB differs from them, otherwise 0.
- For ops 0x0 and 0x1 the second adder operand is 0.
REQ-015 For op 0x8, `O` SHALL be 64'h1 if signed A < signed B, otherwise 0; `Cout` and `Oflow` SHALL be 0.
REQ-016 For logic ops, `Cout` and `Oflow` SHALL be 0.
- 0x9: A&B
- 0xA: A|B
- 0xB: A^B
- 0xC: ~A
REQ-017 For shift ops, `Cout` SHALL be the bit shifted out and `Oflow` SHALL be 0.
- 0xD: A<<1 with 0 fill; `Cout`=A[63].
- 0xE: arithmetic right shift by 1 with A[63] fill; `Cout`=A[0].
- 0xF: logical right shift by 1 with 0 fill; `Cout`=A[0].
REQ-018 `Ntive` SHALL equal `O[63]` and `Zero` SHALL equal (`O`==0) for every op, each registered with `O`.
REQ-019 All results SHALL wrap modulo 2^64; `Cin` SHALL be ignored by ops other than 0, 1, 3, 5 and 7.
REQ-020 Every one of the 16 `S` codes SHALL be defined; there are no illegal codes.

Reset
REQ-021 When `rst`=1 at a rising `clk` edge, the outputs SHALL be `O`=0, `Cout`=0, `Oflow`=0, `Ntive`=0 and `Zero`=1, regardless of other inputs.
REQ-022 Reset SHALL take precedence over computation.
REQ-023 The first valid result SHALL appear on the first rising edge with `rst`=0.
REQ-024 Asserting `rst` mid-stream SHALL discard the pending result.

Verification
REQ-025 S=2, A=0FFFFFFFA0000000, B=00000001A1110000 -> next cycle `O`=1000000141110000, `Cout`=0, `Oflow`=0, `Ntive`=0, `Zero`=0.
REQ-026 S=4, A=A765231000000001, B=A765231000000000 -> `O`=0000000000000001, `Cout`=1.
- S=6 with the same operands -> `O`=FFFFFFFFFFFFFFFF, `Cout`=0, `Ntive`=1.
REQ-027 S=2, A=7FFFFFFFFFFFFFFF, B=1 -> `O`=8000000000000000, `Oflow`=1, `Ntive`=1, `Cout`=0.
REQ-028 S=8 checks:
- A=B=0 -> `O`=0, `Zero`=1.
- A=000000000000000A, B=000000000000A000 -> `O`=1.
- Swapped operands -> `O`=0.
REQ-029 S=E, A=E00000AB00CD0000 -> `O`=F000005580668000, `Ntive`=1, `Cout`=0.
- S=9, A=all ones, B=123456789ABCDEF0 -> `O`=123456789ABCDEF0.
REQ-030 Reset checks:
- `rst`=1 during a stream of ops -> next edge `O`=0 and `Zero`=1.
- Release -> the result appears exactly one cycle later.

Source files
------------

// File: rtl/alux64.sv
// -----------------------------------------------------------------------------
// alux64 -- 64-bit registered ALU with carry, overflow, negative and zero flags.
//
// Every rising clk edge loads the result of the current operands and opcode
// into the output registers (one-cycle latency, one operation per cycle).
// All eight arithmetic opcodes share a single 65-bit adder; bit 64 of the sum
// is the carry-out, so for subtraction Cout=1 means "no borrow".
//
// Ports
//   clk   in   1  clock, all state updates on the rising edge
//   rst   in   1  synchronous active-high reset
//   A     in  64  operand A
//   B     in  64  operand B
//   Cin   in   1  carry-in (ops 0, 1, 3, 5, 7 only)
//   S     in   4  operation select
//   O     out 64  registered result
//   Cout  out  1  registered carry / shifted-out bit
//   Oflow out  1  registered signed overflow (adder ops only)
//   Ntive out  1  registered O[63]
//   Zero  out  1  registered (O == 0)
// -----------------------------------------------------------------------------
module alux64 (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] A,
   input  logic [63:0] B,
   input  logic        Cin,
   input  logic [3:0]  S,
   output logic [63:0] O,
   output logic        Cout,
   output logic        Oflow,
   output logic        Ntive,
   output logic        Zero
);

   typedef enum logic [3:0] {
      OP_A_CIN     = 4'h0,
      OP_B_CIN     = 4'h1,
      OP_ADD       = 4'h2,
      OP_ADD_CIN   = 4'h3,
      OP_SUB_AB    = 4'h4,
      OP_SUB_AB_C  = 4'h5,
      OP_SUB_BA    = 4'h6,
      OP_SUB_BA_C  = 4'h7,
      OP_SLT       = 4'h8,
      OP_AND       = 4'h9,
      OP_OR        = 4'hA,
      OP_XOR       = 4'hB,
      OP_NOT       = 4'hC,
      OP_SHL       = 4'hD,
      OP_SAR       = 4'hE,
      OP_SHR       = 4'hF
   } op_e;

   op_e         op;
   logic [63:0] add_a;
   logic [63:0] add_b;
   logic        add_c;
   logic [64:0] sum;
   logic        add_oflow;

   logic [63:0] o_d,     o_q;
   logic        cout_d,  cout_q;
   logic        oflow_d, oflow_q;
   logic        ntive_d, ntive_q;
   logic        zero_d,  zero_q;

   assign op = op_e'(S);

   // Adder operand steering. Non-adder opcodes leave the defaults in place;
   // their sum is simply not selected below.
   // NOTE: every signal gets a default before the case so no path through
   // this block leaves a variable unassigned, which would infer a latch.
   always_comb begin
      add_a = A;
      add_b = '0;
      add_c = 1'b0;
      unique case (op)
         OP_A_CIN:    begin add_a = A; add_b = '0; add_c = Cin;  end
         OP_B_CIN:    begin add_a = B; add_b = '0; add_c = Cin;  end
         OP_ADD:      begin add_a = A; add_b = B;  add_c = 1'b0; end
         OP_ADD_CIN:  begin add_a = A; add_b = B;  add_c = Cin;  end
         OP_SUB_AB:   begin add_a = A; add_b = ~B; add_c = 1'b1; end
         OP_SUB_AB_C: begin add_a = A; add_b = ~B; add_c = Cin;  end
         OP_SUB_BA:   begin add_a = B; add_b = ~A; add_c = 1'b1; end
         OP_SUB_BA_C: begin add_a = B; add_b = ~A; add_c = Cin;  end
         default:     ;
      endcase
   end

   assign sum = {1'b0, add_a} + {1'b0, add_b} + {64'd0, add_c};

   // Signed overflow: operands agree in sign but the result does not.
   assign add_oflow = (add_a[63] == add_b[63]) && (sum[63] != add_a[63]);

   always_comb begin
      o_d     = sum[63:0];
      cout_d  = sum[64];
      oflow_d = add_oflow;
      unique case (op)
         OP_SLT: begin
            o_d     = {63'd0, ($signed(A) < $signed(B))};
            cout_d  = 1'b0;
            oflow_d = 1'b0;
         end
         OP_AND: begin o_d = A & B; cout_d = 1'b0; oflow_d = 1'b0; end
         OP_OR:  begin o_d = A | B; cout_d = 1'b0; oflow_d = 1'b0; end
         OP_XOR: begin o_d = A ^ B; cout_d = 1'b0; oflow_d = 1'b0; end
         OP_NOT: begin o_d = ~A;    cout_d = 1'b0; oflow_d = 1'b0; end
         OP_SHL: begin o_d = {A[62:0], 1'b0};  cout_d = A[63]; oflow_d = 1'b0; end
         OP_SAR: begin o_d = {A[63], A[63:1]}; cout_d = A[0];  oflow_d = 1'b0; end
         OP_SHR: begin o_d = {1'b0, A[63:1]};  cout_d = A[0];  oflow_d = 1'b0; end
         default: ;  // adder opcodes keep the defaults above
      endcase
      ntive_d = o_d[63];
      zero_d  = (o_d == 64'd0);
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples its pre-edge inputs, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         o_q     <= '0;
         cout_q  <= 1'b0;
         oflow_q <= 1'b0;
         ntive_q <= 1'b0;
         zero_q  <= 1'b1;  // reset value O=0 is consistent with Zero=1
      end else begin
         o_q     <= o_d;
         cout_q  <= cout_d;
         oflow_q <= oflow_d;
         ntive_q <= ntive_d;
         zero_q  <= zero_d;
      end
   end

   assign O     = o_q;
   assign Cout  = cout_q;
   assign Oflow = oflow_q;
   assign Ntive = ntive_q;
   assign Zero  = zero_q;

endmodule

// File: tb/tb_alux64.sv
// -----------------------------------------------------------------------------
// tb_alux64 -- directed-vector bench for alux64.
// The driver applies one vector per cycle on the falling edge and queues the
// hand-computed response; the monitor pops one entry per rising edge and
// compares it against the registered outputs.
// -----------------------------------------------------------------------------
module tb_alux64;

   typedef struct {
      logic [63:0] o;
      logic        cout;
      logic        oflow;
      logic        ntive;
      logic        zero;
      string       name;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] A;
   logic [63:0] B;
   logic        Cin;
   logic [3:0]  S;
   logic [63:0] O;
   logic        Cout;
   logic        Oflow;
   logic        Ntive;
   logic        Zero;

   exp_t sb[$];
   int   total  = 0;
   int   passed = 0;

   alux64 dut (
      .clk   (clk),
      .rst   (rst),
      .A     (A),
      .B     (B),
      .Cin   (Cin),
      .S     (S),
      .O     (O),
      .Cout  (Cout),
      .Oflow (Oflow),
      .Ntive (Ntive),
      .Zero  (Zero)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(input logic [63:0] o, input logic c, input logic v,
                               input logic n, input logic z, input string name);
      exp_t e;
      e.o = o; e.cout = c; e.oflow = v; e.ntive = n; e.zero = z; e.name = name;
      return e;
   endfunction

   task automatic check(input exp_t e);
      total++;
      if (O === e.o && Cout === e.cout && Oflow === e.oflow &&
          Ntive === e.ntive && Zero === e.zero) begin
         passed++;
      end else begin
         $display("FAIL %s: got O=%h C=%b V=%b N=%b Z=%b, want O=%h C=%b V=%b N=%b Z=%b",
                  e.name, O, Cout, Oflow, Ntive, Zero,
                  e.o, e.cout, e.oflow, e.ntive, e.zero);
      end
   endtask

   task automatic issue(input logic r, input logic [3:0] s, input logic [63:0] a,
                        input logic [63:0] b, input logic c, input exp_t e);
      @(negedge clk);
      rst = r; S = s; A = a; B = b; Cin = c;
      sb.push_back(e);
   endtask

   // Monitor: the DUT produces a result every cycle; each queued expectation
   // belongs to the edge that follows its stimulus.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check(e);
         end
      end
   end

   initial begin
      rst = 1'b1; S = 4'h0; A = '0; B = '0; Cin = 1'b0;

      // Reset with busy operands still yields the reset state.
      issue(1, 4'h2, 64'h1234, 64'h5678, 1, mk(64'h0, 0, 0, 0, 1, "reset"));

      // First valid result on the first edge with rst=0.
      issue(0, 4'h2, 64'h0FFFFFFFA0000000, 64'h00000001A1110000, 0,
            mk(64'h1000000141110000, 0, 0, 0, 0, "add_carry_chain"));
      issue(0, 4'h4, 64'hA765231000000001, 64'hA765231000000000, 0,
            mk(64'h0000000000000001, 1, 0, 0, 0, "sub_a_b"));
      issue(0, 4'h6, 64'hA765231000000001, 64'hA765231000000000, 0,
            mk(64'hFFFFFFFFFFFFFFFF, 0, 0, 1, 0, "sub_b_a"));
      issue(0, 4'h2, 64'h7FFFFFFFFFFFFFFF, 64'h1, 0,
            mk(64'h8000000000000000, 0, 1, 1, 0, "add_oflow"));
      issue(0, 4'h8, 64'h0, 64'h0, 1, mk(64'h0, 0, 0, 0, 1, "slt_equal"));
      issue(0, 4'h8, 64'h000000000000000A, 64'h000000000000A000, 0,
            mk(64'h1, 0, 0, 0, 0, "slt_less"));
      issue(0, 4'h8, 64'h000000000000A000, 64'h000000000000000A, 0,
            mk(64'h0, 0, 0, 0, 1, "slt_swapped"));
      issue(0, 4'h8, 64'hFFFFFFFFFFFFFFFF, 64'h1, 0,
            mk(64'h1, 0, 0, 0, 0, "slt_signed"));
      issue(0, 4'hE, 64'hE00000AB00CD0000, 64'h0, 1,
            mk(64'hF000005580668000, 0, 0, 1, 0, "sar_spec"));
      issue(0, 4'h9, 64'hFFFFFFFFFFFFFFFF, 64'h123456789ABCDEF0, 0,
            mk(64'h123456789ABCDEF0, 0, 0, 0, 0, "and"));
      issue(0, 4'h0, 64'h5, 64'hFFFF, 1, mk(64'h6, 0, 0, 0, 0, "a_plus_cin"));
      issue(0, 4'h0, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1,
            mk(64'h0, 1, 0, 0, 1, "a_cin_wrap"));
      issue(0, 4'h1, 64'h1, 64'h7FFFFFFFFFFFFFFF, 1,
            mk(64'h8000000000000000, 0, 1, 1, 0, "b_cin_oflow"));
      issue(0, 4'h3, 64'h1, 64'h2, 1, mk(64'h4, 0, 0, 0, 0, "add_cin"));
      issue(0, 4'h2, 64'h1, 64'h2, 1, mk(64'h3, 0, 0, 0, 0, "add_ignores_cin"));
      issue(0, 4'h5, 64'd10, 64'd3, 0, mk(64'd6, 1, 0, 0, 0, "sub_ab_cin0"));
      issue(0, 4'h7, 64'd3, 64'd10, 1, mk(64'd7, 1, 0, 0, 0, "sub_ba_cin1"));
      issue(0, 4'h4, 64'h8000000000000000, 64'h1, 0,
            mk(64'h7FFFFFFFFFFFFFFF, 1, 1, 0, 0, "sub_oflow"));
      issue(0, 4'h4, 64'd5, 64'd5, 1, mk(64'h0, 1, 0, 0, 1, "sub_zero"));
      issue(0, 4'hA, 64'hF0, 64'h0F, 1, mk(64'hFF, 0, 0, 0, 0, "or"));
      issue(0, 4'hB, 64'hFF, 64'h0F, 0, mk(64'hF0, 0, 0, 0, 0, "xor"));
      issue(0, 4'hC, 64'h0, 64'h5, 0, mk(64'hFFFFFFFFFFFFFFFF, 0, 0, 1, 0, "not"));
      issue(0, 4'hD, 64'h8000000000000001, 64'h0, 1, mk(64'h2, 1, 0, 0, 0, "shl"));
      issue(0, 4'hF, 64'h8000000000000001, 64'h0, 0,
            mk(64'h4000000000000000, 1, 0, 0, 0, "shr"));
      issue(0, 4'hE, 64'h8000000000000001, 64'h0, 0,
            mk(64'hC000000000000000, 1, 0, 1, 0, "sar_neg"));

      // Mid-stream reset discards the pending op; release resumes next cycle.
      issue(0, 4'h2, 64'h1, 64'h1, 0, mk(64'h2, 0, 0, 0, 0, "pre_reset"));
      issue(1, 4'h2, 64'h3, 64'h3, 0, mk(64'h0, 0, 0, 0, 1, "mid_reset"));
      issue(0, 4'h2, 64'h4, 64'h4, 0, mk(64'h8, 0, 0, 0, 0, "post_release"));

      // Drain the scoreboard within a bounded number of cycles.
      for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
      #2;
      if (sb.size() != 0) begin
         total++;
         $display("FAIL drain: %0d results outstanding, want 0", sb.size());
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
